// File: rtl/axi_node_resp_router_if.sv
// rtl/axi_node_resp_router_if.sv - response channel bundle between slave side, router and masters
interface axi_node_resp_router_if #(
    parameter int ID_WIDTH  = 4,
    parameter int AUX_WIDTH = 8,
    parameter int N_MASTER  = 3
);
    logic [ID_WIDTH-1:0]  inp_id_i;
    logic [AUX_WIDTH-1:0] inp_aux_i;
    logic                 inp_last_i;
    logic                 inp_valid_i;
    logic                 inp_ready_o;
    logic [ID_WIDTH-1:0]  oup_id_o;
    logic [AUX_WIDTH-1:0] oup_aux_o;
    logic                 oup_last_o;
    logic [N_MASTER-1:0]  oup_valid_o;
    logic [N_MASTER-1:0]  oup_ready_i;

    // Router side: consumes the slave beat, drives the shared master beat
    modport master (
        input  inp_id_i, inp_aux_i, inp_last_i, inp_valid_i, oup_ready_i,
        output inp_ready_o, oup_id_o, oup_aux_o, oup_last_o, oup_valid_o
    );

    // Environment side: slave produces beats, masters consume them
    modport slave (
        output inp_id_i, inp_aux_i, inp_last_i, inp_valid_i, oup_ready_i,
        input  inp_ready_o, oup_id_o, oup_aux_o, oup_last_o, oup_valid_o
    );
endinterface

// File: rtl/axi_node_resp_router.sv
// rtl/axi_node_resp_router.sv - one-entry response router with optional outstanding counters (AXI_NODE_RESP_ROUTER_CNT_EN)
module axi_node_resp_router #(
    parameter int AUX_WIDTH = 0,
    parameter int ID_WIDTH  = 0,
    parameter int N_MASTER  = 0,
    parameter int CNT_WIDTH = 4,
    localparam int SEL_W    = ($clog2(N_MASTER) > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    axi_node_resp_router_if.master        bus,
    input  logic                          req_valid_i,
    input  logic                          req_ready_i,
    input  logic [SEL_W-1:0]              req_mst_i,
    output logic [N_MASTER*CNT_WIDTH-1:0] outstanding_o,
    output logic                          err_o,
    output logic                          underflow_o
);
    localparam logic [SEL_W:0] NM = (SEL_W+1)'(N_MASTER);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_MASTER-1:0]  r_oh;
    logic [ID_WIDTH-1:0]  r_id;
    logic [AUX_WIDTH-1:0] r_aux;
    logic                 r_last;
    logic                 r_err;

    logic [SEL_W-1:0]     w_in_idx;
    logic                 w_in_ok;
    logic [N_MASTER-1:0]  w_in_oh;
    logic                 w_in_hs;
    logic                 w_load;
    logic                 w_drain;

    assign w_in_idx = bus.inp_id_i[ID_WIDTH-1 -: SEL_W];
    assign w_in_ok  = {1'b0, w_in_idx} < NM;
    assign w_drain  = |(bus.oup_valid_o & bus.oup_ready_i);
    assign w_in_hs  = bus.inp_valid_i & bus.inp_ready_o;
    assign w_load   = w_in_hs & w_in_ok;

    // Decode the incoming master index to a one-hot valid pattern
    always_comb begin
        w_in_oh = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            w_in_oh[m] = (int'(w_in_idx) == m);
        end
    end

    // State register: EMPTY/FULL occupancy of the output slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_EMPTY;
        else         r_state <= w_state_nxt;
    end

    // Next state: a refill keeps the slot full even while it drains
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_load) w_state_nxt = S_FULL;
            S_FULL:  if (w_load) w_state_nxt = S_FULL;
                     else if (w_drain) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Outputs: accept when empty or when the held beat leaves this cycle
    always_comb begin
        bus.inp_ready_o = 1'b1;
        bus.oup_valid_o = '0;
        if (r_state == S_FULL) begin
            bus.inp_ready_o = w_drain;
            bus.oup_valid_o = r_oh;
        end
    end

    // Beat storage; out-of-range beats are swallowed and flagged next cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_oh   <= '0;
            r_id   <= '0;
            r_aux  <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_in_hs & ~w_in_ok;
            if (w_load) begin
                r_oh   <= w_in_oh;
                r_id   <= bus.inp_id_i;
                r_aux  <= bus.inp_aux_i;
                r_last <= bus.inp_last_i;
            end
        end
    end

    assign bus.oup_id_o   = r_id;
    assign bus.oup_aux_o  = r_aux;
    assign bus.oup_last_o = r_last;
    assign err_o          = r_err;

`ifdef AXI_NODE_RESP_ROUTER_CNT_EN
    logic [N_MASTER-1:0][CNT_WIDTH-1:0] r_cnt;
    logic                               r_uf;
    logic [N_MASTER-1:0]                w_inc;
    logic [N_MASTER-1:0]                w_dec;

    // Per-master grant and last-beat completion events
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            w_inc[m] = req_valid_i & req_ready_i & (int'(req_mst_i) == m);
            w_dec[m] = bus.oup_valid_o[m] & bus.oup_ready_i[m] & r_last;
        end
    end

    // Saturating counters; a decrement at zero holds and latches underflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_uf  <= 1'b0;
        end else begin
            for (int m = 0; m < N_MASTER; m++) begin
                if (w_inc[m] && !w_dec[m]) begin
                    if (r_cnt[m] != '1) r_cnt[m] <= r_cnt[m] + 1'b1;
                end else if (w_dec[m] && !w_inc[m]) begin
                    if (r_cnt[m] == '0) r_uf     <= 1'b1;
                    else                r_cnt[m] <= r_cnt[m] - 1'b1;
                end
            end
        end
    end

    assign outstanding_o = r_cnt;
    assign underflow_o   = r_uf;
`else
    logic w_unused_req;
    assign w_unused_req  = ^{req_valid_i, req_ready_i, req_mst_i};
    assign outstanding_o = '0;
    assign underflow_o   = 1'b0;
`endif
endmodule

// File: tb/tb_axi_node_resp_router.sv
// tb/tb_axi_node_resp_router.sv - directed self-checking bench for axi_node_resp_router
module tb_axi_node_resp_router;
    localparam int NM  = 3;
    localparam int IDW = 4;
    localparam int AXW = 8;
    localparam int CW  = 4;
    localparam int SW  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready = 1'b0;
    logic [SW-1:0] req_mst = '0;
    logic [NM*CW-1:0] outstanding;
    logic          err;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    axi_node_resp_router_if #(.ID_WIDTH(IDW), .AUX_WIDTH(AXW), .N_MASTER(NM)) bus ();

    axi_node_resp_router #(
        .AUX_WIDTH(AXW), .ID_WIDTH(IDW), .N_MASTER(NM), .CNT_WIDTH(CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .req_valid_i   (req_valid),
        .req_ready_i   (req_ready),
        .req_mst_i     (req_mst),
        .outstanding_o (outstanding),
        .err_o         (err),
        .underflow_o   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [IDW-1:0] id, input logic [AXW-1:0] aux, input logic last);
        bus.inp_id_i    = id;
        bus.inp_aux_i   = aux;
        bus.inp_last_i  = last;
        bus.inp_valid_i = 1'b1;
    endtask

    initial begin
        bus.inp_id_i    = '0;
        bus.inp_aux_i   = '0;
        bus.inp_last_i  = 1'b0;
        bus.inp_valid_i = 1'b0;
        bus.oup_ready_i = 3'b111;

        // Reset values
        step(); step();
        check("rst_valid", 32'(bus.oup_valid_o), 32'h0);
        check("rst_id", 32'(bus.oup_id_o), 32'h0);
        check("rst_aux", 32'(bus.oup_aux_o), 32'h0);
        check("rst_last", 32'(bus.oup_last_o), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_cnt", 32'(outstanding), 32'h0);
        check("rst_uf", 32'(underflow), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(bus.inp_ready_o), 32'h1);

        // id 0100 routes to master 1 one cycle later
        beat(4'b0100, 8'hA5, 1'b0);
        step();
        bus.inp_valid_i = 1'b0;
        check("route_valid", 32'(bus.oup_valid_o), 32'h2);
        check("route_id", 32'(bus.oup_id_o), 32'h4);
        check("route_aux", 32'(bus.oup_aux_o), 32'hA5);
        step();
        check("route_drain", 32'(bus.oup_valid_o), 32'h0);

        // Back-to-back beats to master 2, no bubble
        for (int i = 0; i < 3; i++) begin
            beat(4'(8 + i), 8'(8'h10 + i), 1'b0);
            #1;
            check("b2b_ready", 32'(bus.inp_ready_o), 32'h1);
            step();
            check("b2b_valid", 32'(bus.oup_valid_o), 32'h4);
            check("b2b_id", 32'(bus.oup_id_o), 32'(8 + i));
        end
        bus.inp_valid_i = 1'b0;
        step();
        check("b2b_empty", 32'(bus.oup_valid_o), 32'h0);

        // Backpressure on master 0 for five cycles, then same-cycle drain/refill
        bus.oup_ready_i = 3'b110;
        beat(4'b0000, 8'h3C, 1'b0);
        step();
        beat(4'b0001, 8'h3D, 1'b0);
        #1;
        check("bp_ready", 32'(bus.inp_ready_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_id", 32'(bus.oup_id_o), 32'h0);
            check("bp_hold_aux", 32'(bus.oup_aux_o), 32'h3C);
            check("bp_hold_valid", 32'(bus.oup_valid_o), 32'h1);
            check("bp_hold_ready", 32'(bus.inp_ready_o), 32'h0);
        end
        bus.oup_ready_i = 3'b111;
        #1;
        check("bp_release_ready", 32'(bus.inp_ready_o), 32'h1);
        step();
        bus.inp_valid_i = 1'b0;
        check("bp_refill_id", 32'(bus.oup_id_o), 32'h1);
        check("bp_refill_aux", 32'(bus.oup_aux_o), 32'h3D);
        check("bp_refill_valid", 32'(bus.oup_valid_o), 32'h1);
        step();
        check("bp_empty", 32'(bus.oup_valid_o), 32'h0);

        // Out-of-range index 3 is dropped with a single err pulse
        beat(4'b1100, 8'hEE, 1'b1);
        #1;
        check("drop_ready", 32'(bus.inp_ready_o), 32'h1);
        step();
        bus.inp_valid_i = 1'b0;
        check("drop_err", 32'(err), 32'h1);
        check("drop_valid", 32'(bus.oup_valid_o), 32'h0);
        step();
        check("drop_err_clr", 32'(err), 32'h0);
        check("drop_still_empty", 32'(bus.oup_valid_o), 32'h0);

        // Outstanding counters
        req_valid = 1'b1;
        req_ready = 1'b1;
        req_mst   = 2'd1;
        step(); step();
        req_mst = 2'd3;
        step();
        req_valid = 1'b0;
        beat(4'b0100, 8'h55, 1'b1);
        step();
        bus.inp_valid_i = 1'b0;
        step();
`ifdef AXI_NODE_RESP_ROUTER_CNT_EN
        check("cnt_m1", 32'(outstanding), 32'h010);
        check("cnt_no_uf", 32'(underflow), 32'h0);
`else
        check("cnt_off", 32'(outstanding), 32'h0);
`endif
        beat(4'b0000, 8'h66, 1'b1);
        step();
        bus.inp_valid_i = 1'b0;
        step(); step();
`ifdef AXI_NODE_RESP_ROUTER_CNT_EN
        check("uf_set", 32'(underflow), 32'h1);
        check("uf_cnt_m0", 32'(outstanding), 32'h010);
`else
        check("uf_off", 32'(underflow), 32'h0);
`endif
        req_valid = 1'b1;
        req_mst   = 2'd2;
        for (int i = 0; i < 17; i++) step();
        req_valid = 1'b0;
        step();
`ifdef AXI_NODE_RESP_ROUTER_CNT_EN
        check("cnt_sat", 32'(outstanding), 32'hF10);
        check("uf_sticky", 32'(underflow), 32'h1);
`else
        check("cnt_off_sat", 32'(outstanding), 32'h0);
`endif

        // Reset while FULL discards the held beat immediately
        bus.oup_ready_i = 3'b000;
        beat(4'b1000, 8'h77, 1'b0);
        step();
        bus.inp_valid_i = 1'b0;
        check("full_before_rst", 32'(bus.oup_valid_o), 32'h4);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.oup_valid_o), 32'h0);
        check("rst_mid_id", 32'(bus.oup_id_o), 32'h0);
        check("rst_mid_cnt", 32'(outstanding), 32'h0);
        check("rst_mid_uf", 32'(underflow), 32'h0);
        step();
        rst_n = 1'b1;
        bus.oup_ready_i = 3'b111;
        #1;
        check("rst_after_ready", 32'(bus.inp_ready_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
